// File: rtl/wgt_i2c_xfer_if.sv
// Source-read / destination-write bus of the weight img2col unit.
// master = transfer unit, slave = BRAM side.
interface wgt_i2c_xfer_if #(
  parameter int DATA_WID = 16,
  parameter int LANES    = 8,
  parameter int ADDR_WID = 10
);
  logic                      rd_en;
  logic [ADDR_WID-1:0]       rd_addr;
  logic [DATA_WID*LANES-1:0] rd_data;
  logic                      wr_en;
  logic [ADDR_WID-1:0]       wr_addr;
  logic [DATA_WID*LANES-1:0] wr_data;

  modport master (
    output rd_en,
    output rd_addr,
    input  rd_data,
    output wr_en,
    output wr_addr,
    output wr_data
  );

  modport slave (
    input  rd_en,
    input  rd_addr,
    output rd_data,
    input  wr_en,
    input  wr_addr,
    input  wr_data
  );
endinterface

// File: rtl/wgt_i2c_xfer.sv
// Weight img2col transfer: streams kernel words from source BRAM
// into the cube weight buffer in (pixel, group) x kernel order.
module wgt_i2c_xfer #(
  parameter int DATA_WID = 16,
  parameter int LANES    = 8,
  parameter int ADDR_WID = 10,
  parameter int RD_LAT   = 2
) (
  input  logic                clock,
  input  logic                rst_n,
  input  logic                start,
  input  logic                abort,
  input  logic [2:0]          kernel_size,
  input  logic [4:0]          ch_groups,
  input  logic [4:0]          num_kernels,
  input  logic [3:0]          valid_num,
  input  logic [ADDR_WID-1:0] src_base,
  input  logic [ADDR_WID-1:0] dst_base,
  output logic                ready,
  output logic                done,
  output logic                cfg_err,
  wgt_i2c_xfer_if.master      bus
);
  localparam int W = DATA_WID * LANES;
  localparam logic [RD_LAT-1:0] TAIL =
    RD_LAT'(1) << (RD_LAT - 1);

  typedef enum logic [1:0] {
    IDLE, LOAD, ISSUE, DRAIN
  } state_t;

  state_t state;

  logic [2:0]          ks_q;
  logic [4:0]          g_q;
  logic [4:0]          n_q;
  logic [3:0]          vn_q;
  logic [ADDR_WID-1:0] sb_q;
  logic [ADDR_WID-1:0] db_q;

  logic [5:0]  p_c;
  logic [4:0]  g_c;
  logic [4:0]  k_c;
  logic [13:0] d_off;
  logic [13:0] gk_off;

  logic                rd_en_q;
  logic [ADDR_WID-1:0] rd_addr_q;
  logic [ADDR_WID-1:0] d_cur;
  logic                lg_cur;

  logic [RD_LAT-1:0]   vld;
  logic [RD_LAT-1:0]   lgp;
  logic [ADDR_WID-1:0] dpipe [RD_LAT];
  logic [W-1:0]        hold;
  logic [W-1:0]        masked;

  logic [5:0]  kk;
  logic [8:0]  gn;
  logic        cfg_ok;
  logic        p_last;
  logic        g_last;
  logic        k_last;
  logic [5:0]  p_n;
  logic [4:0]  g_n;
  logic [4:0]  k_n;
  logic [13:0] gk_n;
  logic [13:0] doff_n;
  int          vn_i;

  assign kk = 6'(ks_q) * 6'(ks_q);
  assign gn = 9'(g_q) * 9'(n_q);

  // Odd 3-bit sizes are exactly {1,3,5,7}.
  assign cfg_ok = ks_q[0]
                  && (g_q != 5'd0) && (g_q <= 5'd16)
                  && (n_q != 5'd0) && (n_q <= 5'd16);

  assign p_last = (p_c == kk - 6'd1);
  assign g_last = (g_c == g_q - 5'd1);
  assign k_last = (k_c == n_q - 5'd1);

  // Source offset is linear in issue order; destination
  // offset is stepped: +G*N per pixel, reset to g*N+k on wrap.
  always_comb begin
    p_n    = p_c + 6'd1;
    g_n    = g_c;
    k_n    = k_c;
    gk_n   = gk_off;
    doff_n = d_off + 14'(gn);
    if (p_last) begin
      p_n = 6'd0;
      if (g_last) begin
        g_n  = 5'd0;
        k_n  = k_c + 5'd1;
        gk_n = 14'(k_c) + 14'd1;
      end else begin
        g_n  = g_c + 5'd1;
        gk_n = gk_off + 14'(n_q);
      end
      doff_n = gk_n;
    end
  end

  always_comb begin
    vn_i   = (vn_q == 4'd0) ? LANES : int'(vn_q);
    masked = bus.rd_data;
    for (int i = 0; i < LANES; i++) begin
      if (lgp[RD_LAT-1] && (i >= vn_i)) begin
        masked[i*DATA_WID +: DATA_WID] = '0;
      end
    end
  end

  assign bus.rd_en   = rd_en_q;
  assign bus.rd_addr = rd_addr_q;
  assign bus.wr_en   = vld[RD_LAT-1];
  assign bus.wr_addr = dpipe[RD_LAT-1];
  assign bus.wr_data = vld[RD_LAT-1] ? masked : hold;

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ready     <= 1'b1;
      done      <= 1'b0;
      cfg_err   <= 1'b0;
      ks_q      <= '0;
      g_q       <= '0;
      n_q       <= '0;
      vn_q      <= '0;
      sb_q      <= '0;
      db_q      <= '0;
      p_c       <= '0;
      g_c       <= '0;
      k_c       <= '0;
      d_off     <= '0;
      gk_off    <= '0;
      rd_en_q   <= 1'b0;
      rd_addr_q <= '0;
      d_cur     <= '0;
      lg_cur    <= 1'b0;
      vld       <= '0;
      lgp       <= '0;
      hold      <= '0;
      for (int i = 0; i < RD_LAT; i++) begin
        dpipe[i] <= '0;
      end
    end else begin
      done    <= 1'b0;
      cfg_err <= 1'b0;

      for (int i = RD_LAT - 1; i > 0; i--) begin
        vld[i]   <= vld[i-1];
        lgp[i]   <= lgp[i-1];
        dpipe[i] <= dpipe[i-1];
      end
      vld[0]   <= rd_en_q;
      lgp[0]   <= lg_cur;
      dpipe[0] <= d_cur;

      if (vld[RD_LAT-1]) begin
        hold <= masked;
      end

      if (abort && (state != IDLE)) begin
        state   <= IDLE;
        ready   <= 1'b1;
        rd_en_q <= 1'b0;
        vld     <= '0;
      end else begin
        unique case (state)
          IDLE: begin
            // The done cycle shows ready=1 but a job just ended.
            if (start && !done) begin
              ks_q  <= kernel_size;
              g_q   <= ch_groups;
              n_q   <= num_kernels;
              vn_q  <= valid_num;
              sb_q  <= src_base;
              db_q  <= dst_base;
              ready <= 1'b0;
              state <= LOAD;
            end
          end
          LOAD: begin
            if (!cfg_ok) begin
              cfg_err <= 1'b1;
              ready   <= 1'b1;
              state   <= IDLE;
            end else begin
              rd_en_q   <= 1'b1;
              rd_addr_q <= sb_q;
              p_c       <= '0;
              g_c       <= '0;
              k_c       <= '0;
              d_off     <= '0;
              gk_off    <= '0;
              d_cur     <= db_q;
              lg_cur    <= (g_q == 5'd1);
              state     <= ISSUE;
            end
          end
          ISSUE: begin
            if (p_last && g_last && k_last) begin
              rd_en_q <= 1'b0;
              state   <= DRAIN;
            end else begin
              rd_addr_q <= rd_addr_q + 1'b1;
              p_c       <= p_n;
              g_c       <= g_n;
              k_c       <= k_n;
              d_off     <= doff_n;
              gk_off    <= gk_n;
              d_cur     <= db_q + ADDR_WID'(doff_n);
              lg_cur    <= (g_n == g_q - 5'd1);
            end
          end
          DRAIN: begin
            if (vld == TAIL) begin
              done  <= 1'b1;
              ready <= 1'b1;
              state <= IDLE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_wgt_i2c_xfer.sv
// Directed bench for wgt_i2c_xfer with a 2-cycle BRAM model
// and logs of every read, write, done and cfg_err cycle.
module tb_wgt_i2c_xfer;
  localparam int DW = 16;
  localparam int LN = 8;
  localparam int AW = 10;
  localparam int RL = 2;

  logic          clock = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [2:0]    kernel_size = '0;
  logic [4:0]    ch_groups = '0;
  logic [4:0]    num_kernels = '0;
  logic [3:0]    valid_num = '0;
  logic [AW-1:0] src_base = '0;
  logic [AW-1:0] dst_base = '0;
  logic          ready;
  logic          done;
  logic          cfg_err;

  int cyc = 0;
  int vectors = 0;
  int errs = 0;

  logic [127:0] mem [1024];
  logic [127:0] rp0;
  logic [127:0] rp1;

  int            rd_cyc [$];
  logic [AW-1:0] rd_adr [$];
  int            wr_cyc [$];
  logic [AW-1:0] wr_adr [$];
  logic [127:0]  wr_dat [$];
  int            done_cyc [$];
  int            err_cyc [$];

  wgt_i2c_xfer_if #(
    .DATA_WID(DW), .LANES(LN), .ADDR_WID(AW)
  ) bus ();

  wgt_i2c_xfer #(
    .DATA_WID(DW), .LANES(LN),
    .ADDR_WID(AW), .RD_LAT(RL)
  ) dut (
    .clock(clock),
    .rst_n(rst_n),
    .start(start),
    .abort(abort),
    .kernel_size(kernel_size),
    .ch_groups(ch_groups),
    .num_kernels(num_kernels),
    .valid_num(valid_num),
    .src_base(src_base),
    .dst_base(dst_base),
    .ready(ready),
    .done(done),
    .cfg_err(cfg_err),
    .bus(bus)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  always @(posedge clock) begin
    rp0 <= mem[bus.rd_addr];
    rp1 <= rp0;
  end
  assign bus.rd_data = rp1;

  always @(negedge clock) begin
    if (bus.rd_en === 1'b1) begin
      rd_cyc.push_back(cyc);
      rd_adr.push_back(bus.rd_addr);
    end
    if (bus.wr_en === 1'b1) begin
      wr_cyc.push_back(cyc);
      wr_adr.push_back(bus.wr_addr);
      wr_dat.push_back(bus.wr_data);
    end
    if (done === 1'b1) done_cyc.push_back(cyc);
    if (cfg_err === 1'b1) err_cyc.push_back(cyc);
  end

  function automatic logic [127:0] word(input int a);
    logic [127:0] w;
    for (int l = 0; l < LN; l++) begin
      w[l*16 +: 16] = 16'(a * 8 + l + 'h1000);
    end
    return w;
  endfunction

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic clear_log;
    rd_cyc.delete();
    rd_adr.delete();
    wr_cyc.delete();
    wr_adr.delete();
    wr_dat.delete();
    done_cyc.delete();
    err_cyc.delete();
  endtask

  task automatic go(
    input  logic [2:0]    ks,
    input  logic [4:0]    g,
    input  logic [4:0]    n,
    input  logic [3:0]    vn,
    input  logic [AW-1:0] sb,
    input  logic [AW-1:0] db,
    output int            s
  );
    kernel_size = ks;
    ch_groups   = g;
    num_kernels = n;
    valid_num   = vn;
    src_base    = sb;
    dst_base    = db;
    start       = 1'b1;
    s           = cyc;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (done_cyc.size() > 0) break;
      tick();
    end
    tick();
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) tick();
    vectors++;
    if (ready !== 1'b1) begin
      errs++;
      $display("FAIL reset_ready got %b want 1", ready);
    end
    vectors++;
    if ({done, cfg_err} !== 2'b00) begin
      errs++;
      $display("FAIL reset_pulses got %b want 00",
               {done, cfg_err});
    end
    vectors++;
    if ({bus.rd_en, bus.rd_addr} !== '0) begin
      errs++;
      $display("FAIL reset_rd got %b/%0d want 0/0",
               bus.rd_en, bus.rd_addr);
    end
    vectors++;
    if ({bus.wr_en, bus.wr_addr} !== '0) begin
      errs++;
      $display("FAIL reset_wr got %b/%0d want 0/0",
               bus.wr_en, bus.wr_addr);
    end
    vectors++;
    if (bus.wr_data !== '0) begin
      errs++;
      $display("FAIL reset_wdata got %h want 0", bus.wr_data);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single;
    int s;
    int d;
    clear_log();
    go(3'd3, 5'd1, 5'd1, 4'd8, '0, '0, s);
    while (cyc < s + 13) begin
      start = (cyc == s + 5);
      tick();
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    @(negedge clock);
    vectors++;
    if (ready !== 1'b1) begin
      errs++;
      $display("FAIL single_start_in_done ready %b want 1", ready);
    end
    repeat (10) tick();
    vectors++;
    if (rd_adr.size() !== 9) begin
      errs++;
      $display("FAIL single_rd_count got %0d want 9",
               rd_adr.size());
    end
    for (int i = 0; i < rd_adr.size() && i < 9; i++) begin
      vectors++;
      if (rd_adr[i] !== AW'(i) || rd_cyc[i] !== s + 2 + i) begin
        errs++;
        $display("FAIL single_rd%0d got %0d@%0d want %0d@%0d",
                 i, rd_adr[i], rd_cyc[i], i, s + 2 + i);
      end
    end
    vectors++;
    if (wr_adr.size() !== 9) begin
      errs++;
      $display("FAIL single_wr_count got %0d want 9",
               wr_adr.size());
    end
    for (int i = 0; i < wr_adr.size() && i < 9; i++) begin
      vectors++;
      if (wr_adr[i] !== AW'(i) || wr_cyc[i] !== s + 4 + i
          || wr_dat[i] !== word(i)) begin
        errs++;
        $display("FAIL single_wr%0d got %0d@%0d %h want %0d@%0d %h",
                 i, wr_adr[i], wr_cyc[i], wr_dat[i],
                 i, s + 4 + i, word(i));
      end
    end
    d = (done_cyc.size() > 0) ? done_cyc[0] - s : -1;
    vectors++;
    if (done_cyc.size() !== 1 || d !== 13) begin
      errs++;
      $display("FAIL single_done got %0d pulses at +%0d want 1 at +13",
               done_cyc.size(), d);
    end
  endtask

  task automatic test_transpose;
    int s;
    int d;
    int ea [6] = '{32, 35, 33, 36, 34, 37};
    clear_log();
    go(3'd1, 5'd2, 5'd3, 4'd8, 10'd0, 10'd32, s);
    wait_done(40);
    for (int i = 0; i < rd_adr.size() && i < 6; i++) begin
      vectors++;
      if (rd_adr[i] !== AW'(i)) begin
        errs++;
        $display("FAIL xpose_rd%0d got %0d want %0d",
                 i, rd_adr[i], i);
      end
    end
    vectors++;
    if (wr_adr.size() !== 6) begin
      errs++;
      $display("FAIL xpose_wr_count got %0d want 6", wr_adr.size());
    end
    for (int i = 0; i < wr_adr.size() && i < 6; i++) begin
      vectors++;
      if (wr_adr[i] !== AW'(ea[i]) || wr_dat[i] !== word(i)) begin
        errs++;
        $display("FAIL xpose_wr%0d got %0d %h want %0d %h",
                 i, wr_adr[i], wr_dat[i], ea[i], word(i));
      end
    end
    d = (done_cyc.size() > 0) ? done_cyc[0] - s : -1;
    vectors++;
    if (d !== 10) begin
      errs++;
      $display("FAIL xpose_done got +%0d want +10", d);
    end
  endtask

  task automatic test_wrap;
    int s;
    int ra [6] = '{1021, 1022, 1023, 0, 1, 2};
    int wa [6] = '{1022, 0, 2, 1023, 1, 3};
    clear_log();
    go(3'd1, 5'd3, 5'd2, 4'd0, 10'd1021, 10'd1022, s);
    wait_done(40);
    vectors++;
    if (rd_adr.size() !== 6 || wr_adr.size() !== 6) begin
      errs++;
      $display("FAIL wrap_counts got %0d/%0d want 6/6",
               rd_adr.size(), wr_adr.size());
    end
    for (int i = 0; i < wr_adr.size() && i < 6; i++) begin
      vectors++;
      if (rd_adr[i] !== AW'(ra[i]) || wr_adr[i] !== AW'(wa[i])
          || wr_dat[i] !== word(ra[i])) begin
        errs++;
        $display("FAIL wrap_%0d got r%0d w%0d %h want r%0d w%0d %h",
                 i, rd_adr[i], wr_adr[i], wr_dat[i],
                 ra[i], wa[i], word(ra[i]));
      end
    end
  endtask

  task automatic test_lane_mask;
    int s;
    logic [127:0] e0;
    logic [127:0] e1;
    e0 = '1;
    e1 = {80'h0, 48'hFFFF_FFFF_FFFF};
    mem[0] = '1;
    mem[1] = '1;
    clear_log();
    go(3'd1, 5'd2, 5'd1, 4'd3, '0, '0, s);
    wait_done(40);
    vectors++;
    if (wr_dat.size() !== 2) begin
      errs++;
      $display("FAIL mask_count got %0d want 2", wr_dat.size());
    end else begin
      vectors++;
      if (wr_dat[0] !== e0) begin
        errs++;
        $display("FAIL mask_g0 got %h want %h", wr_dat[0], e0);
      end
      vectors++;
      if (wr_dat[1] !== e1) begin
        errs++;
        $display("FAIL mask_g1 got %h want %h", wr_dat[1], e1);
      end
    end
    repeat (2) tick();
    vectors++;
    if (bus.wr_en !== 1'b0 || bus.wr_data !== e1) begin
      errs++;
      $display("FAIL mask_hold got %b %h want 0 %h",
               bus.wr_en, bus.wr_data, e1);
    end
    mem[0] = word(0);
    mem[1] = word(1);
  endtask

  task automatic test_cfg_err;
    int s;
    int e;
    logic [2:0] ks [3] = '{3'd4, 3'd3, 3'd3};
    logic [4:0] gg [3] = '{5'd1, 5'd0, 5'd1};
    logic [4:0] nn [3] = '{5'd1, 5'd1, 5'd17};
    for (int t = 0; t < 3; t++) begin
      clear_log();
      go(ks[t], gg[t], nn[t], 4'd8, '0, '0, s);
      while (cyc < s + 2) tick();
      @(negedge clock);
      vectors++;
      if (ready !== 1'b1 || cfg_err !== 1'b1) begin
        errs++;
        $display("FAIL cfg%0d_pulse got rdy%b err%b want 1 1",
                 t, ready, cfg_err);
      end
      repeat (8) tick();
      e = (err_cyc.size() > 0) ? err_cyc[0] - s : -1;
      vectors++;
      if (err_cyc.size() !== 1 || e !== 2 || rd_adr.size() !== 0
          || done_cyc.size() !== 0) begin
        errs++;
        $display("FAIL cfg%0d_log got err%0d@+%0d rd%0d done%0d want 1@+2 0 0",
                 t, err_cyc.size(), e, rd_adr.size(),
                 done_cyc.size());
      end
    end
  endtask

  task automatic test_abort;
    int s;
    int lr;
    int lw;
    clear_log();
    go(3'd5, 5'd1, 5'd1, 4'd8, '0, '0, s);
    while (cyc < s + 11) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    @(negedge clock);
    vectors++;
    if (ready !== 1'b1 || bus.rd_en !== 1'b0
        || bus.wr_en !== 1'b0) begin
      errs++;
      $display("FAIL abort_next got rdy%b rd%b wr%b want 1 0 0",
               ready, bus.rd_en, bus.wr_en);
    end
    repeat (40) tick();
    lr = (rd_cyc.size() > 0) ? rd_cyc[rd_cyc.size()-1] - s : -1;
    lw = (wr_cyc.size() > 0) ? wr_cyc[wr_cyc.size()-1] - s : -1;
    vectors++;
    if (rd_cyc.size() !== 10 || lr !== 11) begin
      errs++;
      $display("FAIL abort_rd got %0d last +%0d want 10 last +11",
               rd_cyc.size(), lr);
    end
    vectors++;
    if (wr_cyc.size() !== 8 || lw !== 11) begin
      errs++;
      $display("FAIL abort_wr got %0d last +%0d want 8 last +11",
               wr_cyc.size(), lw);
    end
    vectors++;
    if (done_cyc.size() !== 0) begin
      errs++;
      $display("FAIL abort_done got %0d want 0", done_cyc.size());
    end
    clear_log();
    abort = 1'b1;
    go(3'd1, 5'd1, 5'd2, 4'd8, '0, 10'd100, s);
    abort = 1'b0;
    wait_done(30);
    lr = (done_cyc.size() > 0) ? done_cyc[0] - s : -1;
    vectors++;
    if (done_cyc.size() !== 1 || lr !== 6) begin
      errs++;
      $display("FAIL abort_rerun_done got %0d at +%0d want 1 at +6",
               done_cyc.size(), lr);
    end
    vectors++;
    if (wr_adr.size() !== 2) begin
      errs++;
      $display("FAIL abort_rerun_wr got %0d want 2", wr_adr.size());
    end else if (wr_adr[0] !== 10'd100 || wr_adr[1] !== 10'd101
                 || wr_dat[1] !== word(1)) begin
      errs++;
      $display("FAIL abort_rerun_data got %0d %0d %h want 100 101 %h",
               wr_adr[0], wr_adr[1], wr_dat[1], word(1));
    end
  endtask

  task automatic test_reset_mid;
    int s;
    clear_log();
    go(3'd3, 5'd1, 5'd1, 4'd8, '0, '0, s);
    while (cyc < s + 5) tick();
    rst_n = 1'b0;
    #1;
    vectors++;
    if (ready !== 1'b1 || done !== 1'b0 || cfg_err !== 1'b0) begin
      errs++;
      $display("FAIL rstmid_ctl got %b%b%b want 100",
               ready, done, cfg_err);
    end
    vectors++;
    if (bus.rd_en !== 1'b0 || bus.rd_addr !== '0
        || bus.wr_en !== 1'b0 || bus.wr_addr !== '0
        || bus.wr_data !== '0) begin
      errs++;
      $display("FAIL rstmid_bus got %b %0d %b %0d %h want zeros",
               bus.rd_en, bus.rd_addr, bus.wr_en,
               bus.wr_addr, bus.wr_data);
    end
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (30) tick();
    vectors++;
    if (done_cyc.size() !== 0 || rd_adr.size() !== 3
        || wr_adr.size() !== 1) begin
      errs++;
      $display("FAIL rstmid_after got done%0d rd%0d wr%0d want 0 3 1",
               done_cyc.size(), rd_adr.size(), wr_adr.size());
    end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = word(i);
    test_reset();
    test_single();
    test_transpose();
    test_wrap();
    test_lane_mask();
    test_cfg_err();
    test_abort();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, errs);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/wgt_i2c_xfer.md
Name: wgt_i2c_xfer

Overview:
- Parametrised weight img2col transfer unit for the mini Davinci datapath.
- Reads packed kernel words from a source weight BRAM and writes them to the cube-side weight buffer in img2col matrix order: row = (pixel, channel group), column = kernel.
- Supports multiple kernels, multiple channel groups, kernel sizes 1/3/5/7, zeroing of invalid lanes, configurable BRAM read latency and abort.

Parameters:
DATA_WID, 16, bits per weight element
LANES, 8, elements per BRAM word
ADDR_WID, 10, source/destination address width
RD_LAT, 2, source BRAM read latency in cycles (>=1)

Ports:
clock  in  1  system clock
rst_n  in  1  asynchronous active-low reset
start  in  1  start request, accepted only while ready=1
abort  in  1  synchronous abort, terminates the job
kernel_size  in  3  1, 3, 5 or 7
ch_groups  in  5  channel groups per kernel, 1..16
num_kernels  in  5  kernels (output channels), 1..16
valid_num  in  4  valid lanes in the last channel group, 1..LANES (0 means LANES)
src_base  in  ADDR_WID  source start address
dst_base  in  ADDR_WID  destination start address
ready  out  1  idle, can accept start
done  out  1  one-cycle pulse when a job completes
cfg_err  out  1  one-cycle pulse when start is rejected
rd_en  out  1  source read enable
rd_addr  out  ADDR_WID  source read address
rd_data  in  DATA_WID*LANES  source data, valid RD_LAT cycles after rd_en
wr_en  out  1  destination write enable
wr_addr  out  ADDR_WID  destination write address
wr_data  out  DATA_WID*LANES  destination data, lane 0 in the LSBs

Behaviour:
- Reset values: ready=1, done=0, cfg_err=0, rd_en=0, rd_addr=0, wr_en=0, wr_addr=0, wr_data=0. The delay pipeline and all counters clear.
- Reset mid-job returns the block to IDLE immediately. No done pulse is generated.
- FSM states: IDLE, LOAD, ISSUE, DRAIN.
- IDLE:
  - start=1 latches kernel_size, ch_groups, num_kernels, valid_num, src_base and dst_base.
  - Goes to LOAD. ready falls in the same edge.
- LOAD:
  - Validates the latched configuration.
  - Invalid if ksize is not in {1,3,5,7}, ch_groups is 0 or >16, or num_kernels is 0 or >16.
  - Invalid: cfg_err pulses, ready=1, return to IDLE, no reads issued.
  - Valid: go to ISSUE.
- ISSUE:
  - Issues one read per cycle. rd_en=1 from the first ISSUE cycle, which is two cycles after start is accepted.
  - Loop nesting, innermost first: pixel p (0..K²-1), channel group g, kernel k.
  - Source address = src_base + ((k*G + g)*K² + p).
  - Destination address = dst_base + ((p*G + g)*N + k).
  - Address sums are truncated mod 2^ADDR_WID.
  - Total reads = K²*G*N (max 12544). After the last read, go to DRAIN.
- Delay pipeline:
  - Destination address and a last-group flag travel through an RD_LAT-deep shift register alongside rd_en.
  - wr_en equals rd_en delayed by exactly RD_LAT cycles. wr_addr is the matching destination address.
  - wr_data is rd_data with lanes >= valid_num forced to 0, but only when g = G-1. Other groups pass through unmodified.
  - wr_data holds its value when wr_en=0.
- DRAIN:
  - Waits until the pipeline is empty.
  - done pulses one cycle after the last wr_en. ready returns to 1 in the same cycle, then back to IDLE.
- start while ready=0 is ignored, including start during the done cycle.
- abort=1 in LOAD, ISSUE or DRAIN, on the next edge:
  - rd_en=0, the pipeline is flushed, and no further wr_en occurs.
  - Return to IDLE with ready=1. No done pulse.
- abort in IDLE has no effect. If abort and start arrive in the same IDLE cycle, start is accepted.
- One read per cycle with no stalls. Job latency from start to done = 2 + K²*G*N + RD_LAT cycles.

Test Plan:
- Single kernel: K=3, G=1, N=1, valid_num=8, RD_LAT=2, bases 0 -> 9 reads at addr 0..8, writes to 0..8 two cycles later with identical data, done at cycle 13 after start.
- Transpose: K=1, G=2, N=3, src_base=0, dst_base=32 -> reads at 0..5; write addresses in order 32, 35, 33, 36, 34, 37; data of src 1 lands at 35.
- Lane mask: K=1, G=2, N=1, valid_num=3, all source data 0xFFFF -> first write all lanes 0xFFFF; second write lanes 0..2 = 0xFFFF, lanes 3..7 = 0.
- Config error: kernel_size=4, or ch_groups=0 -> cfg_err pulses two cycles after start, no rd_en, ready back to 1, no done.
- Abort: K=5, G=1, N=1, abort on the 10th rd_en cycle -> no rd_en afterwards, no wr_en after that edge, no done, ready=1 next cycle; a new job then completes normally.
- Reset mid-ISSUE: drop rst_n during the 4th read -> all outputs at reset values immediately, no done after release; start ignored during the job and during the done cycle.
